osd_stm_trace_capture: RTL and testbench

- Upstream feeder for the system trace module (STM) in the debug subsystem.
- Snoops the CPU retire/writeback trace port and keeps shadow copies of the software trace registers.
- When a retired instruction is the trace marker `l.nop NOP_IMM`, it emits one registered event on trace_valid/trace_id/trace_value.
- Its outputs connect 1:1 to the STM trace inputs.

---
 rtl/osd_stm_trace_capture.sv | 112 +++++++++++
 tb/tb_osd_stm_trace_capture.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/osd_stm_trace_capture.sv
// STM feeder: shadows the software trace GPRs and emits one registered event per l.nop trace marker.
// Optional build macro OSD_STM_TRACE_CAPTURE_COUNT_EN adds a saturating event_count output.
module osd_stm_trace_capture #(
  parameter int unsigned VALWIDTH   = 64,
  parameter logic [4:0]  REG_ID     = 5'd3,
  parameter logic [4:0]  REG_VAL_LO = 5'd4,
  parameter logic [4:0]  REG_VAL_HI = 5'd5,
  parameter logic [15:0] NOP_IMM    = 16'h0008
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                insn_valid,
  input  logic [31:0]         insn,
  input  logic                wb_valid,
  input  logic [4:0]          wb_reg,
  input  logic [31:0]         wb_data,
`ifdef OSD_STM_TRACE_CAPTURE_COUNT_EN
  output logic [15:0]         event_count,
`endif
  output logic                trace_valid,
  output logic [15:0]         trace_id,
  output logic [VALWIDTH-1:0] trace_value
);

  localparam int unsigned IDW  = 16;
  localparam int unsigned HALF = 32;

  generate
    if (VALWIDTH != 32 && VALWIDTH != 64) begin : g_bad_width
      $error("osd_stm_trace_capture: VALWIDTH must be 32 or 64");
    end
  endgenerate

  logic [IDW-1:0]      shadow_id;
  logic [HALF-1:0]     shadow_lo;
  logic [IDW-1:0]      id_nxt;
  logic [HALF-1:0]     lo_nxt;
  logic [VALWIDTH-1:0] value_nxt;
  logic                wb_live;
  logic                hit_id;
  logic                hit_lo;
  logic                marker;
  logic                fire;
  logic                unused_insn_bits;

  assign unused_insn_bits = ^insn[23:16];

  // r0 is hard-wired zero in the CPU, so writes to it never reach a shadow
  always_comb begin
    wb_live = wb_valid && (wb_reg != 5'd0);
    hit_id  = wb_live && (wb_reg == REG_ID);
    hit_lo  = wb_live && (wb_reg == REG_VAL_LO);
    id_nxt  = hit_id ? wb_data[IDW-1:0] : shadow_id;
    lo_nxt  = hit_lo ? wb_data : shadow_lo;
    marker  = insn_valid && (insn[31:24] == 8'h15) && (insn[15:0] == NOP_IMM);
    fire    = marker && enable;
  end

  // Shadows track writebacks independent of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_id <= '0;
      shadow_lo <= '0;
    end else begin
      shadow_id <= id_nxt;
      shadow_lo <= lo_nxt;
    end
  end

  generate
    if (VALWIDTH == 64) begin : g_hi
      logic            hit_hi;
      logic [HALF-1:0] shadow_hi;
      logic [HALF-1:0] hi_nxt;

      assign hit_hi    = wb_live && (wb_reg == REG_VAL_HI);
      assign hi_nxt    = hit_hi ? wb_data : shadow_hi;
      assign value_nxt = {hi_nxt, lo_nxt};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_hi <= '0;
        else        shadow_hi <= hi_nxt;
      end
    end else begin : g_lo_only
      assign value_nxt = VALWIDTH'(lo_nxt);
    end
  endgenerate

  // Event register: forwarded snapshot captured on the marker edge, held until the next event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid <= 1'b0;
      trace_id    <= '0;
      trace_value <= '0;
    end else begin
      trace_valid <= fire;
      if (fire) begin
        trace_id    <= id_nxt;
        trace_value <= value_nxt;
      end
    end
  end

`ifdef OSD_STM_TRACE_CAPTURE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                event_count <= '0;
    else if (fire && (event_count != 16'hFFFF)) event_count <= event_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_osd_stm_trace_capture.sv
// Self-checking bench for osd_stm_trace_capture: directed test-plan steps plus a randomized run
// against a GPR-file reference model. Honours OSD_STM_TRACE_CAPTURE_COUNT_EN when defined.
module tb_osd_stm_trace_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        insn_valid;
  logic [31:0] insn;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        trace_valid;
  logic [15:0] trace_id;
  logic [63:0] trace_value;
`ifdef OSD_STM_TRACE_CAPTURE_COUNT_EN
  logic [15:0] event_count;
`endif

  osd_stm_trace_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .insn_valid  (insn_valid),
    .insn        (insn),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
`ifdef OSD_STM_TRACE_CAPTURE_COUNT_EN
    .event_count (event_count),
`endif
    .trace_valid (trace_valid),
    .trace_id    (trace_id),
    .trace_value (trace_value)
  );

  always #5 clk = ~clk;

  // Reference model: architectural GPR view plus the expected output registers
  logic [31:0] gpr [32];
  logic        exp_valid;
  logic [15:0] exp_id;
  logic [63:0] exp_value;
  int unsigned exp_count;
  int          vectors = 0;
  int          miscompares = 0;

  localparam logic [31:0] MARK   = 32'h15000008;
  localparam logic [31:0] NOPINS = 32'h15000000;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
    exp_valid = 1'b0;
    exp_id    = 16'h0;
    exp_value = 64'h0;
    exp_count = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("trace_valid", 64'(trace_valid), 64'(exp_valid));
    chk("trace_id",    64'(trace_id),    64'(exp_id));
    chk("trace_value", trace_value,      exp_value);
`ifdef OSD_STM_TRACE_CAPTURE_COUNT_EN
    chk("event_count", 64'(event_count), 64'(exp_count));
`endif
  endtask

  // One clock: drive, advance the model from the spec rules, then sample 1ns after the edge
  task automatic cycle(input logic en, input logic iv, input logic [31:0] ins,
                       input logic wv, input logic [4:0] wr, input logic [31:0] wd);
    logic mk;
    enable = en; insn_valid = iv; insn = ins;
    wb_valid = wv; wb_reg = wr; wb_data = wd;
    if (wv && wr != 5'd0) gpr[wr] = wd;
    mk = iv && (ins[31:24] == 8'h15) && (ins[15:0] == 16'h0008);
    exp_valid = mk && en;
    if (exp_valid) begin
      exp_id    = gpr[3][15:0];
      exp_value = {gpr[5], gpr[4]};
      if (exp_count < 32'hFFFF) exp_count++;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    logic [4:0]  wr;
    rst_n = 1'b0; enable = 1'b1; insn_valid = 1'b0; insn = '0;
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    model_reset();

    // Reset held with random traffic including markers
    for (int i = 0; i < 6; i++) begin
      enable = 1'b1; insn_valid = 1'b1;
      insn = (i % 2 == 0) ? MARK : $urandom;
      wb_valid = 1'b1; wb_reg = 5'($urandom_range(1, 7)); wb_data = $urandom;
      @(posedge clk); #1;
      check_outputs();
    end
    rst_n = 1'b1;
    idle();

    // Basic event with full 64-bit value, then valid drops
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 5'd3, 32'h0000ABCD);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 5'd4, 32'hDEADBEEF);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 5'd5, 32'h01234567);
    cycle(1'b1, 1'b1, MARK, 1'b0, 5'd0, 32'h0);
    chk("basic_id", 64'(trace_id), 64'h000000000000ABCD);
    chk("basic_value", trace_value, 64'h01234567DEADBEEF);
    idle();

    // Same-cycle writeback forwards into the event
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 5'd4, 32'h1);
    cycle(1'b1, 1'b1, MARK, 1'b1, 5'd4, 32'h55);
    chk("fwd_lo", 64'(trace_value[31:0]), 64'h55);
    idle();

    // Back-to-back markers with r3 rewritten each cycle; bits [23:16] are don't-care
    cycle(1'b1, 1'b1, MARK, 1'b1, 5'd3, 32'h1);
    cycle(1'b1, 1'b1, 32'h15A50008, 1'b1, 5'd3, 32'h2);
    cycle(1'b1, 1'b1, MARK, 1'b1, 5'd3, 32'h3);
    chk("b2b_last_id", 64'(trace_id), 64'h3);
    idle();

    // Non-marker l.nop and invalid marker
    cycle(1'b1, 1'b1, NOPINS | 32'h4, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 1'b0, MARK, 1'b0, 5'd0, 32'h0);

    // Disabled marker: no event, but shadow still tracks r3
    cycle(1'b0, 1'b1, MARK, 1'b1, 5'd3, 32'h77);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    cycle(1'b1, 1'b1, MARK, 1'b0, 5'd0, 32'h0);
    chk("en_id", 64'(trace_id), 64'h77);

    // r0 writes never reach shadows
    cycle(1'b1, 1'b1, MARK, 1'b1, 5'd0, 32'hFFFFFFFF);
    chk("r0_id", 64'(trace_id), 64'h77);
    idle();

    // Reset asserted while an event is due
    enable = 1'b1; insn_valid = 1'b1; insn = MARK; wb_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_outputs();
    #2 rst_n = 1'b1;
    idle();
    idle();

`ifdef OSD_STM_TRACE_CAPTURE_COUNT_EN
    // Five markers from reset, then preset near saturation
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, MARK, 1'b0, 5'd0, 32'h0);
    chk("count5", 64'(event_count), 64'd5);
    idle();
    force dut.event_count = 16'hFFFE;
    #1 release dut.event_count;
    exp_count = 32'hFFFE;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, MARK, 1'b0, 5'd0, 32'h0);
    chk("count_sat", 64'(event_count), 64'hFFFF);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r  = $urandom;
      wr = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ins = $urandom;
        1:       ins = {8'h15, 8'($urandom), 16'($urandom_range(0, 15))};
        default: ins = {8'h15, 8'($urandom), 16'h0008};
      endcase
      cycle(1'($urandom_range(0, 3) != 0), 1'(r[0] | r[1]), ins, r[2], wr, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
